fpu_sequencer: RTL and testbench

- Multi-cycle sequencer for the FPU attached to the single-cycle MIPS core.
- On a decoded FP instruction it freezes PC/fetch, issues a start pulse to the FPU, and counts a per-operation fixed latency.
- It then asserts the FP register-file writeback for exactly one cycle and releases the PC.
- It sits between the main decoder (which raises fp_valid) and the FPU datapath and FP register file.

---
 rtl/fpu_sequencer.sv | 115 +++++++++++
 tb/tb_fpu_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fpu_sequencer.sv
// Multi-cycle FPU sequencer: stalls the single-cycle core, pulses the FPU start, waits a per-op latency, then writes back once.
// Optional FPU_SEQ_PERF_EN adds a saturating stall_cycles counter.
module fpu_sequencer #(
    parameter int ADD_LAT = 2,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fp_valid,
    input  logic [2:0]  fp_op,
    input  logic [4:0]  fp_fd,
    output logic        stall,
    output logic        busy,
    output logic        fpu_start,
    output logic [1:0]  fpu_op,
    output logic        wb_en,
    output logic [4:0]  wb_fd,
`ifdef FPU_SEQ_PERF_EN
    output logic [31:0] stall_cycles,
`endif
    output logic        fp_illegal
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    // The counter is preloaded with LAT-1 so that EXEC spans exactly LAT cycles
    localparam logic [7:0] ADD_M1 = 8'(ADD_LAT - 1);
    localparam logic [7:0] MUL_M1 = 8'(MUL_LAT - 1);
    localparam logic [7:0] DIV_M1 = 8'(DIV_LAT - 1);

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic [7:0]  lat_m1;
    logic        start_nx, wb_en_nx;
    logic [1:0]  op_nx;
    logic [4:0]  fd_nx;

    always_comb begin
        case (fp_op[1:0])
            2'b10:   lat_m1 = MUL_M1;
            2'b11:   lat_m1 = DIV_M1;
            default: lat_m1 = ADD_M1;
        endcase
    end

    assign busy = (state != IDLE);

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        start_nx   = 1'b0;
        wb_en_nx   = 1'b0;
        op_nx      = fpu_op;
        fd_nx      = wb_fd;
        stall      = 1'b0;
        fp_illegal = 1'b0;
        case (state)
            IDLE: begin
                if (fp_valid) begin
                    if (fp_op[2]) begin
                        fp_illegal = 1'b1;
                    end else begin
                        stall    = 1'b1;
                        state_nx = EXEC;
                        cnt_nx   = lat_m1;
                        start_nx = 1'b1;
                        op_nx    = fp_op[1:0];
                        fd_nx    = fp_fd;
                    end
                end
            end
            EXEC: begin
                stall = 1'b1;
                if (cnt == 8'd0) begin
                    state_nx = WB;
                    wb_en_nx = 1'b1;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            // fp_valid here still belongs to the instruction being retired
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            fpu_op    <= 2'b00;
            wb_fd     <= 5'd0;
            fpu_start <= 1'b0;
            wb_en     <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            fpu_op    <= op_nx;
            wb_fd     <= fd_nx;
            fpu_start <= start_nx;
            wb_en     <= wb_en_nx;
        end
    end

`ifdef FPU_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= 32'd0;
        else if (stall && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fpu_sequencer.sv
// Self-checking bench for fpu_sequencer: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with sporadic resets.
module tb_fpu_sequencer;

    localparam int ADD_LAT = 2;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fp_valid = 1'b0;
    logic [2:0]  fp_op = 3'd0;
    logic [4:0]  fp_fd = 5'd0;
    logic        stall, busy, fpu_start, wb_en, fp_illegal;
    logic [1:0]  fpu_op;
    logic [4:0]  wb_fd;
`ifdef FPU_SEQ_PERF_EN
    logic [31:0] stall_cycles;
`endif

    fpu_sequencer #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst(rst), .fp_valid(fp_valid), .fp_op(fp_op), .fp_fd(fp_fd),
        .stall(stall), .busy(busy), .fpu_start(fpu_start), .fpu_op(fpu_op),
        .wb_en(wb_en), .wb_fd(wb_fd),
`ifdef FPU_SEQ_PERF_EN
        .stall_cycles(stall_cycles),
`endif
        .fp_illegal(fp_illegal)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [4:0] fd, input logic r);
        @(posedge clk);
        #1;
        fp_valid = v;
        fp_op    = op;
        fp_fd    = fd;
        rst      = r;
    endtask

    // Reference model: an accepted op is described by its accept cycle and latency only
    bit          m_ready  = 1'b0;
    bit          m_active = 1'b0;
    int          m_t0 = 0;
    int          m_lat = 0;
    logic [1:0]  m_op = 2'd0;
    logic [4:0]  m_fd = 5'd0;
    logic [31:0] m_perf = 32'd0;

    function automatic int lat_of(input logic [1:0] op);
        if (op == 2'b10) return MUL_LAT;
        if (op == 2'b11) return DIV_LAT;
        return ADD_LAT;
    endfunction

    function automatic bit exp_stall();
        if (m_active) return (cyc - m_t0) <= m_lat;
        return fp_valid && !fp_op[2];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ready  = 1'b1;
            m_active = 1'b0;
            m_op     = 2'd0;
            m_fd     = 5'd0;
            m_perf   = 32'd0;
        end else begin
            if (exp_stall() && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
            if (m_active) begin
                if (cyc - m_t0 == m_lat + 1) m_active = 1'b0;
            end else if (fp_valid && !fp_op[2]) begin
                m_active = 1'b1;
                m_t0     = cyc;
                m_lat    = lat_of(fp_op[1:0]);
                m_op     = fp_op[1:0];
                m_fd     = fp_fd;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (m_ready) begin
            checkOutput("stall", stall, exp_stall());
            checkOutput("busy", busy, m_active);
            checkOutput("fp_illegal", fp_illegal, !m_active && fp_valid && fp_op[2]);
            checkOutput("fpu_start", fpu_start, m_active && (cyc - m_t0 == 1));
            checkOutput("wb_en", wb_en, m_active && (cyc - m_t0 == m_lat + 1));
            checkOutput("fpu_op", fpu_op, m_op);
            checkOutput("wb_fd", wb_fd, m_fd);
`ifdef FPU_SEQ_PERF_EN
            checkOutput("stall_cycles", stall_cycles, m_perf);
`endif
        end
    end

    initial begin
        int starts;
        logic [2:0] op;

        applyStimulus(0, 3'd0, 5'd0, 1);
        applyStimulus(0, 3'd0, 5'd0, 1);
        @(negedge clk);
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_start", fpu_start, 0);
        checkOutput("rst_wb_en", wb_en, 0);
        checkOutput("rst_fpu_op", fpu_op, 0);
        checkOutput("rst_wb_fd", wb_fd, 0);

        // Add, fd=5: stall T0..T2, start at T1, writeback at T3
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 3'd0, 5'd5, 0);
            @(negedge clk);
            checkOutput("add_stall", stall, i <= 2);
            checkOutput("add_start", fpu_start, i == 1);
            checkOutput("add_wb_en", wb_en, i == 3);
        end
        checkOutput("add_wb_fd", wb_fd, 5);
        applyStimulus(0, 3'd0, 5'd0, 0);
        @(negedge clk);
        checkOutput("add_idle_busy", busy, 0);

        // Div with fp_valid held throughout: single start, writeback at T9
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 3'd3, 5'd9, 0);
            @(negedge clk);
            if (fpu_start) starts++;
            if (i >= 1) checkOutput("div_fpu_op", fpu_op, 3);
            checkOutput("div_stall", stall, i <= 8);
            checkOutput("div_wb_en", wb_en, i == 9);
        end
        checkOutput("div_start_count", starts, 1);
        applyStimulus(0, 3'd0, 5'd0, 0);

        // Back-to-back mul (fd=1) then sub (fd=2) presented at T6
        for (int i = 0; i < 10; i++) begin
            if (i < 6) applyStimulus(1, 3'd2, 5'd1, 0);
            else       applyStimulus(1, 3'd1, 5'd2, 0);
            @(negedge clk);
            if (i == 5) checkOutput("b2b_wb1_fd", wb_fd, 1);
            checkOutput("b2b_wb_en", wb_en, (i == 5) || (i == 9));
            checkOutput("b2b_start", fpu_start, (i == 1) || (i == 7));
        end
        checkOutput("b2b_wb2_fd", wb_fd, 2);

        // Illegal opcode
        applyStimulus(1, 3'd5, 5'd3, 0);
        @(negedge clk);
        checkOutput("ill_flag", fp_illegal, 1);
        checkOutput("ill_stall", stall, 0);
        checkOutput("ill_busy", busy, 0);
        applyStimulus(0, 3'd0, 5'd0, 0);
        @(negedge clk);
        checkOutput("ill_no_start", fpu_start, 0);
        checkOutput("ill_no_wb", wb_en, 0);

        // Reset mid-div aborts without writeback; a following add completes
        for (int i = 0; i < 4; i++) applyStimulus(1, 3'd3, 5'd7, 0);
        applyStimulus(0, 3'd0, 5'd0, 1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 3'd0, 5'd0, 0);
            @(negedge clk);
            checkOutput("abort_wb_en", wb_en, 0);
            checkOutput("abort_busy", busy, 0);
            checkOutput("abort_stall", stall, 0);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 3'd0, 5'd4, 0);
            @(negedge clk);
            checkOutput("post_rst_wb_en", wb_en, i == 3);
        end
        checkOutput("post_rst_wb_fd", wb_fd, 4);

`ifdef FPU_SEQ_PERF_EN
        applyStimulus(0, 3'd0, 5'd0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 3'd0, 5'd1, 0);
        for (int i = 0; i < 6; i++) applyStimulus(1, 3'd2, 5'd2, 0);
        applyStimulus(1, 3'd6, 5'd3, 0);
        applyStimulus(0, 3'd0, 5'd0, 0);
        @(negedge clk);
        checkOutput("perf_total", stall_cycles, 8);
        applyStimulus(0, 3'd0, 5'd0, 1);
        applyStimulus(0, 3'd0, 5'd0, 0);
        @(negedge clk);
        checkOutput("perf_cleared", stall_cycles, 0);
`endif

        // Randomized traffic, mostly legal ops, occasional reset
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) op = 3'($urandom_range(4, 7));
            else                           op = 3'($urandom_range(0, 3));
            applyStimulus($urandom_range(0, 3) != 0, op, 5'($urandom_range(0, 31)),
                          $urandom_range(0, 199) == 0);
        end
        applyStimulus(0, 3'd0, 5'd0, 0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
